// File: rtl/joy_db9md_pkg.sv
// Shared constants for the Mega Drive pad emulation: button indices, pin order, phase codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package joy_db9md_pkg;

   // Button vector bit positions, btn = {Z,Y,X,Mode,Start,A,C,B,U,D,L,R}
   localparam int BTN_R     = 0;
   localparam int BTN_L     = 1;
   localparam int BTN_D     = 2;
   localparam int BTN_U     = 3;
   localparam int BTN_B     = 4;
   localparam int BTN_C     = 5;
   localparam int BTN_A     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_MODE  = 8;
   localparam int BTN_X     = 9;
   localparam int BTN_Y     = 10;
   localparam int BTN_Z     = 11;
   localparam int NUM_BTN   = 12;

   // Pin positions inside pad_out = {p9,p6,p4,p3,p2,p1}
   localparam int PIN_P1   = 0;
   localparam int PIN_P2   = 1;
   localparam int PIN_P3   = 2;
   localparam int PIN_P4   = 3;
   localparam int PIN_P6   = 4;
   localparam int PIN_P9   = 5;
   localparam int NUM_PINS = 6;

   // Phase codes: 3 = ID read (low nibble forced 0), 4 = extended read (forced 1)
   localparam logic [2:0] PHASE_ID      = 3'd3;
   localparam logic [2:0] PHASE_EXT     = 3'd4;
   localparam logic [2:0] PHASE_STD_MAX = 3'd2;

   // Idle level of SELECT; synchronizer stages reset here so reset never fakes an edge
   localparam logic SEL_IDLE = 1'b1;

   // Physical pin view of the output word, MSB first matches pad_out ordering
   typedef struct packed {
      logic p9;
      logic p6;
      logic p4;
      logic p3;
      logic p2;
      logic p1;
   } pad_pins_t;

   // Idle timeout in clock cycles, floored at 2 so the timer has at least one bit
   function automatic int calc_timeout_cycles(input int clk_hz, input int timeout_us);
      int cyc;
      cyc = (clk_hz / 1_000_000) * timeout_us;
      return (cyc < 2) ? 2 : cyc;
   endfunction

endpackage

// File: rtl/db9_sel_sync.sv
// SELECT synchronizer with rise/fall detection; all stages reset to the idle-high level.
// Latency: sel_s_o follows sel_i after STAGES edges; rise/fall valid in that same cycle.
// Backpressure: none, free-running every clock.
module db9_sel_sync
   import joy_db9md_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sel_i,
   output logic sel_s_o,
   output logic rise_o,
   output logic fall_o
);

   // Fewer than two stages is not a safe synchronizer, so clamp upward
   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              sel_d_q;

   // Shift the asynchronous SELECT into the chain
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], sel_i};
   end

   // Synchronizer chain plus one-cycle delayed copy for edge detection
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q  <= {STAGES{SEL_IDLE}};
         sel_d_q <= SEL_IDLE;
      end else begin
         sync_q  <= sync_d;
         sel_d_q <= sync_q[STAGES-1];
      end
   end

   // Edge flags from the synchronized level and its delayed copy
   always_comb begin
      sel_s_o = sync_q[STAGES-1];
      rise_o  = sync_q[STAGES-1] & ~sel_d_q;
      fall_o  = ~sync_q[STAGES-1] & sel_d_q;
   end

endmodule

// File: rtl/joy_db9md_pad.sv
// Mega Drive 3/6-button pad emulation: tracks host SELECT, counts phases, drives active-low pins.
// Latency: sel_in to pad_out SYNC_STAGES+1 edges; btn to pad_out 1 edge.
// Backpressure: none, the host samples the pins whenever it likes.
module joy_db9md_pad
   import joy_db9md_pkg::*;
#(
   parameter int CLK_HZ      = 48_000_000,
   parameter int TIMEOUT_US  = 1500,
   parameter int SYNC_STAGES = 2,
   parameter int SIX_BUTTON  = 1
) (
   input  logic        clk_sys,
   input  logic        RESET_N,
   input  logic        sel_in,
   input  logic [11:0] btn,
   output logic [5:0]  pad_out,
   output logic [2:0]  phase,
   output logic        timeout
);

   localparam int         TO   = calc_timeout_cycles(CLK_HZ, TIMEOUT_US);
   localparam int         TW   = $clog2(TO);
   localparam logic [2:0] PMAX = (SIX_BUTTON != 0) ? PHASE_EXT : PHASE_STD_MAX;

   logic          sel_s;
   logic          sel_rise;
   logic          sel_fall;
   logic          sel_edge;

   logic [2:0]    phase_q, phase_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          timeout_q, timeout_d;
   pad_pins_t     pad_q, pad_d;
   logic [11:0]   b;

   db9_sel_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sel_sync (
      .clk_i   (clk_sys),
      .rst_ni  (RESET_N),
      .sel_i   (sel_in),
      .sel_s_o (sel_s),
      .rise_o  (sel_rise),
      .fall_o  (sel_fall)
   );

   assign sel_edge = sel_rise | sel_fall;

   // Phase and idle timer next state; a SELECT edge takes priority over expiry
   always_comb begin
      timer_d   = timer_q + TW'(1);
      phase_d   = phase_q;
      timeout_d = 1'b0;
      if (sel_edge) begin
         timer_d = '0;
         if (sel_fall && (phase_q < PMAX)) begin
            phase_d = phase_q + 3'd1;
         end
      end else if (timer_q == TW'(TO - 1)) begin
         timer_d   = '0;
         phase_d   = 3'd0;
         timeout_d = 1'b1;
      end
   end

   // Output pin mux, driven from the phase the counter is about to hold
   always_comb begin
      b     = ~btn;
      pad_d = '1;
      if (sel_s) begin
         if ((SIX_BUTTON != 0) && (phase_d == PHASE_ID)) begin
            pad_d = '{p9: b[BTN_C], p6: b[BTN_B], p4: b[BTN_MODE],
                      p3: b[BTN_X], p2: b[BTN_Y], p1: b[BTN_Z]};
         end else begin
            pad_d = '{p9: b[BTN_C], p6: b[BTN_B], p4: b[BTN_R],
                      p3: b[BTN_L], p2: b[BTN_D], p1: b[BTN_U]};
         end
      end else begin
         case (phase_d)
            PHASE_ID:  pad_d = '{p9: b[BTN_START], p6: b[BTN_A], p4: 1'b0,
                                 p3: 1'b0, p2: 1'b0, p1: 1'b0};
            PHASE_EXT: pad_d = '{p9: b[BTN_START], p6: b[BTN_A], p4: 1'b1,
                                 p3: 1'b1, p2: 1'b1, p1: 1'b1};
            default:   pad_d = '{p9: b[BTN_START], p6: b[BTN_A], p4: 1'b0,
                                 p3: 1'b0, p2: b[BTN_D], p1: b[BTN_U]};
         endcase
      end
   end

   // State registers; reset releases all pins high and clears the sequence
   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         phase_q   <= 3'd0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
         pad_q     <= '1;
      end else begin
         phase_q   <= phase_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
         pad_q     <= pad_d;
      end
   end

   assign pad_out = pad_q;
   assign phase   = phase_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_joy_db9md_pad.sv
`timescale 1ns/1ps
module tb_joy_db9md_pad;

   localparam int TO = 960;   // 48 cycles/us * 20 us

   logic        clk;
   logic        rst6_n;
   logic        rst3_n;
   logic        sel;
   logic [11:0] btn;
   logic [5:0]  pad6, pad3;
   logic [2:0]  ph6, ph3;
   logic        to6, to3;

   int n_checks;
   int n_fail;

   typedef struct {
      logic        sel;
      logic [11:0] btn;
      logic [5:0]  pad;
      logic [2:0]  ph;
   } vec_t;

   vec_t vecs[11];

   joy_db9md_pad #(
      .CLK_HZ(48_000_000), .TIMEOUT_US(20), .SYNC_STAGES(2), .SIX_BUTTON(1)
   ) dut6 (
      .clk_sys(clk), .RESET_N(rst6_n), .sel_in(sel), .btn(btn),
      .pad_out(pad6), .phase(ph6), .timeout(to6)
   );

   joy_db9md_pad #(
      .CLK_HZ(48_000_000), .TIMEOUT_US(20), .SYNC_STAGES(2), .SIX_BUTTON(0)
   ) dut3 (
      .clk_sys(clk), .RESET_N(rst3_n), .sel_in(sel), .btn(btn),
      .pad_out(pad3), .phase(ph3), .timeout(to3)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance n clock edges, then settle 1 ns past the edge
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic sel_v, input logic [11:0] btn_v);
      sel    = sel_v;
      btn    = btn_v;
      rst6_n = 1'b0;
      rst3_n = 1'b0;
      cyc(2);
      rst6_n = 1'b1;
      rst3_n = 1'b1;
   endtask

   initial begin
      logic [5:0] low_exp[4];
      logic [5:0] high_exp[3];
      int first_to;
      int pulses;

      n_checks = 0;
      n_fail   = 0;
      rst6_n   = 1'b0;
      rst3_n   = 1'b0;
      sel      = 1'b0;
      btn      = 12'hFFF;

      vecs[0]  = '{1'b1, 12'h000, 6'b111111, 3'd0};
      vecs[1]  = '{1'b1, 12'h011, 6'b100111, 3'd0};
      vecs[2]  = '{1'b1, 12'h00F, 6'b110000, 3'd0};
      vecs[3]  = '{1'b1, 12'h020, 6'b011111, 3'd0};
      vecs[4]  = '{1'b1, 12'hF00, 6'b111111, 3'd0};
      vecs[5]  = '{1'b0, 12'h011, 6'b110011, 3'd1};
      vecs[6]  = '{1'b0, 12'h0C0, 6'b000011, 3'd1};
      vecs[7]  = '{1'b0, 12'h00C, 6'b110000, 3'd1};
      vecs[8]  = '{1'b1, 12'h008, 6'b111110, 3'd1};
      vecs[9]  = '{1'b0, 12'h040, 6'b100011, 3'd2};
      vecs[10] = '{1'b1, 12'h800, 6'b111111, 3'd2};

      low_exp[0]  = 6'b110011;
      low_exp[1]  = 6'b110011;
      low_exp[2]  = 6'b110000;
      low_exp[3]  = 6'b111111;
      high_exp[0] = 6'b111111;
      high_exp[1] = 6'b111111;
      high_exp[2] = 6'b111110;

      // Reset state with SELECT low and everything pressed
      cyc(3);
      check("reset_pad6", 32'(pad6), 32'h3F);
      check("reset_ph6", 32'(ph6), 32'd0);
      check("reset_to6", 32'(to6), 32'd0);
      check("reset_pad3", 32'(pad3), 32'h3F);
      rst6_n = 1'b1;
      rst3_n = 1'b1;
      cyc(4);
      check("post_reset_pad6", 32'(pad6), 32'h00);

      // Latency: btn one edge, SELECT three edges
      do_reset(1'b1, 12'h000);
      cyc(2);
      btn = 12'h011;
      cyc(1);
      check("btn_latency", 32'(pad6), 32'b100111);
      sel = 1'b0;
      cyc(2);
      check("sel_latency_2", 32'(pad6), 32'b100111);
      cyc(1);
      check("sel_latency_3", 32'(pad6), 32'b110011);
      check("sel_latency_ph", 32'(ph6), 32'd1);

      // Table of static reads
      do_reset(1'b1, 12'h000);
      cyc(2);
      for (int i = 0; i < 11; i++) begin
         sel = vecs[i].sel;
         btn = vecs[i].btn;
         cyc(6);
         check($sformatf("vec%0d_pad6", i), 32'(pad6), 32'(vecs[i].pad));
         check($sformatf("vec%0d_ph6", i), 32'(ph6), 32'(vecs[i].ph));
         check($sformatf("vec%0d_pad3", i), 32'(pad3), 32'(vecs[i].pad));
      end

      // Six-button sequence, 96-cycle half periods
      do_reset(1'b1, 12'h800);
      cyc(10);
      for (int i = 1; i <= 4; i++) begin
         sel = 1'b0;
         cyc(48);
         check($sformatf("seq_low%0d_ph", i), 32'(ph6), 32'(i));
         check($sformatf("seq_low%0d_pad", i), 32'(pad6), 32'(low_exp[i-1]));
         cyc(48);
         if (i < 4) begin
            sel = 1'b1;
            cyc(48);
            check($sformatf("seq_high%0d_pad", i), 32'(pad6), 32'(high_exp[i-1]));
            cyc(48);
         end
      end

      // Timeout: exact arrival edge, single pulse, phase cleared
      sel      = 1'b1;
      first_to = 0;
      pulses   = 0;
      for (int k = 1; k <= TO + 20; k++) begin
         cyc(1);
         if (to6) begin
            pulses++;
            if (first_to == 0) first_to = k;
         end
      end
      check("timeout_edge", 32'(first_to), 32'(TO + 3));
      check("timeout_pulses", 32'(pulses), 32'd1);
      check("timeout_ph", 32'(ph6), 32'd0);
      sel = 1'b0;
      cyc(4);
      check("after_to_pad", 32'(pad6), 32'b110011);
      check("after_to_ph", 32'(ph6), 32'd1);

      // Race: second edge lands on the expiry cycle of the first
      cyc(10);
      sel    = 1'b1;
      pulses = 0;
      for (int k = 1; k <= TO; k++) begin
         cyc(1);
         if (to6) pulses++;
      end
      sel = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         if (to6) pulses++;
      end
      check("race_pulses", 32'(pulses), 32'd0);
      check("race_ph", 32'(ph6), 32'd2);

      // Three-button saturation alongside six-button counting
      do_reset(1'b1, 12'h000);
      cyc(6);
      for (int p = 1; p <= 5; p++) begin
         sel = 1'b0;
         cyc(6);
         check($sformatf("sat%0d_ph3", p), 32'(ph3), 32'((p > 2) ? 2 : p));
         check($sformatf("sat%0d_pad3", p), 32'(pad3), 32'b110011);
         check($sformatf("sat%0d_ph6", p), 32'(ph6), 32'((p > 4) ? 4 : p));
         sel = 1'b1;
         cyc(6);
      end

      // Mid-sequence reset during the ID phase
      do_reset(1'b1, 12'h000);
      cyc(6);
      for (int p = 1; p <= 3; p++) begin
         sel = 1'b0;
         cyc(6);
         if (p < 3) begin
            sel = 1'b1;
            cyc(6);
         end
      end
      check("mid_ph6_before", 32'(ph6), 32'd3);
      check("mid_pad6_before", 32'(pad6), 32'b110000);
      rst6_n = 1'b0;
      rst3_n = 1'b0;
      cyc(1);
      check("mid_rst_ph6", 32'(ph6), 32'd0);
      check("mid_rst_pad6", 32'(pad6), 32'h3F);
      check("mid_rst_ph3", 32'(ph3), 32'd0);
      check("mid_rst_pad3", 32'(pad3), 32'h3F);
      check("mid_rst_to6", 32'(to6), 32'd0);
      rst6_n = 1'b1;
      rst3_n = 1'b1;
      cyc(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
